// File: rtl/edge_event_arbiter_amisha.sv
// Rising-edge capture on N level inputs with one pending event per channel.
// A round-robin arbiter hands a shared resource to one channel at a time, with a start/done handshake and a timeout abort.
module edge_event_arbiter_amisha #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned IDW    = $clog2(N)
) (
  input  logic           clk_amisha,
  input  logic           reset_amisha,
  input  logic [N-1:0]   level_amisha,
  input  logic           done_amisha,
  output logic           start_amisha,
  output logic [N-1:0]   grant_amisha,
  output logic [IDW-1:0] grant_id_amisha,
  output logic           busy_amisha,
  output logic           timeout_amisha,
  output logic [N-1:0]   drop_amisha
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   prev_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [IDW-1:0] rr_last_q, rr_last_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   grant_d;
  logic [IDW-1:0] grant_id_d;
  logic           busy_d, start_d, timeout_d;
  logic [N-1:0]   drop_d;
  logic [N-1:0]   rise;
  logic [N-1:0]   clr;
  logic [IDW-1:0] sel;
  logic           found;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    count_d    = count_q;
    grant_d    = grant_amisha;
    grant_id_d = grant_id_amisha;
    busy_d     = busy_amisha;
    start_d    = 1'b0;
    timeout_d  = 1'b0;
    clr        = '0;
    sel        = '0;
    found      = 1'b0;
    rise       = level_amisha & ~prev_q;

    // Search starts one past the last winner and wraps around
    for (int unsigned j = 1; j <= N; j++) begin
      int unsigned idx;
      idx = (32'(rr_last_q) + j) % N;
      if (!found && pending_q[IDW'(idx)]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_START;
          clr        = N'(1) << sel;
          grant_d    = N'(1) << sel;
          grant_id_d = sel;
          rr_last_d  = sel;
          busy_d     = 1'b1;
          start_d    = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        count_d = '0;
      end
      S_WAIT: begin
        if (done_amisha) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
        end else if (count_q == CW'(TIMEOUT - 1)) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
          timeout_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
      end
    endcase

    // A new edge beats a same-cycle grant clear, so it is never dropped
    pending_d = (pending_q & ~clr) | rise;
    drop_d    = rise & pending_q & ~clr;
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q         <= S_IDLE;
      prev_q          <= '0;
      pending_q       <= '0;
      rr_last_q       <= IDW'(N - 1);
      count_q         <= '0;
      start_amisha    <= 1'b0;
      grant_amisha    <= '0;
      grant_id_amisha <= '0;
      busy_amisha     <= 1'b0;
      timeout_amisha  <= 1'b0;
      drop_amisha     <= '0;
    end else begin
      state_q         <= state_d;
      prev_q          <= level_amisha;
      pending_q       <= pending_d;
      rr_last_q       <= rr_last_d;
      count_q         <= count_d;
      start_amisha    <= start_d;
      grant_amisha    <= grant_d;
      grant_id_amisha <= grant_id_d;
      busy_amisha     <= busy_d;
      timeout_amisha  <= timeout_d;
      drop_amisha     <= drop_d;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter_amisha.sv
// Directed bench for edge_event_arbiter_amisha with hand-computed expectations.
module tb_edge_event_arbiter_amisha;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;

  logic       clk_amisha = 1'b0;
  logic       reset_amisha;
  logic [3:0] level_amisha;
  logic       done_amisha;
  logic       start_amisha;
  logic [3:0] grant_amisha;
  logic [1:0] grant_id_amisha;
  logic       busy_amisha;
  logic       timeout_amisha;
  logic [3:0] drop_amisha;

  int n_cmp = 0;
  int n_err = 0;

  edge_event_arbiter_amisha #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk_amisha      (clk_amisha),
    .reset_amisha    (reset_amisha),
    .level_amisha    (level_amisha),
    .done_amisha     (done_amisha),
    .start_amisha    (start_amisha),
    .grant_amisha    (grant_amisha),
    .grant_id_amisha (grant_id_amisha),
    .busy_amisha     (busy_amisha),
    .timeout_amisha  (timeout_amisha),
    .drop_amisha     (drop_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one active edge; outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk_amisha);
    #1;
  endtask

  task automatic do_reset();
    reset_amisha = 1'b1;
    level_amisha = 4'b0000;
    done_amisha  = 1'b0;
    tick();
    reset_amisha = 1'b0;
  endtask

  // Called right after the START edge: move to WAIT, then complete with done
  task automatic serve();
    tick();
    done_amisha = 1'b1;
    tick();
    done_amisha = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: single edge on ch2, latency and done handshake
    do_reset();
    check_eq("rst_start", 32'(start_amisha), 32'd0);
    check_eq("rst_busy", 32'(busy_amisha), 32'd0);
    check_eq("rst_grant", 32'(grant_amisha), 32'd0);
    check_eq("rst_id", 32'(grant_id_amisha), 32'd0);
    check_eq("rst_tmo", 32'(timeout_amisha), 32'd0);
    check_eq("rst_drop", 32'(drop_amisha), 32'd0);
    level_amisha = 4'b0100;
    tick();
    check_eq("t1_nostart_k", 32'(start_amisha), 32'd0);
    level_amisha = 4'b0000;
    tick();
    check_eq("t1_start", 32'(start_amisha), 32'd1);
    check_eq("t1_grant", 32'(grant_amisha), 32'h4);
    check_eq("t1_id", 32'(grant_id_amisha), 32'd2);
    check_eq("t1_busy", 32'(busy_amisha), 32'd1);
    tick();
    check_eq("t1_start_pulse", 32'(start_amisha), 32'd0);
    check_eq("t1_busy_wait", 32'(busy_amisha), 32'd1);
    tick();
    tick();
    done_amisha = 1'b1;
    tick();
    done_amisha = 1'b0;
    check_eq("t1_busy_done", 32'(busy_amisha), 32'd0);
    check_eq("t1_grant_done", 32'(grant_amisha), 32'd0);

    // 2: simultaneous edges on ch0,1,3 then wrap-around to ch0
    do_reset();
    level_amisha = 4'b1011;
    tick();
    level_amisha = 4'b0000;
    tick();
    check_eq("t2_g0", 32'(grant_amisha), 32'h1);
    serve();
    tick();
    check_eq("t2_g1", 32'(grant_amisha), 32'h2);
    serve();
    tick();
    check_eq("t2_g3", 32'(grant_amisha), 32'h8);
    check_eq("t2_id3", 32'(grant_id_amisha), 32'd3);
    tick();
    level_amisha = 4'b0001;
    tick();
    level_amisha = 4'b0000;
    check_eq("t2_nodrop", 32'(drop_amisha), 32'd0);
    done_amisha = 1'b1;
    tick();
    done_amisha = 1'b0;
    tick();
    check_eq("t2_wrap_g0", 32'(grant_amisha), 32'h1);
    check_eq("t2_wrap_id0", 32'(grant_id_amisha), 32'd0);
    serve();

    // 3: timeout with done held low
    do_reset();
    level_amisha = 4'b0010;
    tick();
    level_amisha = 4'b0000;
    tick();
    tick();
    repeat (TIMEOUT - 1) tick();
    check_eq("t3_tmo_early", 32'(timeout_amisha), 32'd0);
    check_eq("t3_busy_early", 32'(busy_amisha), 32'd1);
    tick();
    check_eq("t3_tmo", 32'(timeout_amisha), 32'd1);
    check_eq("t3_grant", 32'(grant_amisha), 32'd0);
    check_eq("t3_busy", 32'(busy_amisha), 32'd0);
    done_amisha = 1'b1;
    tick();
    done_amisha = 1'b0;
    check_eq("t3_tmo_pulse", 32'(timeout_amisha), 32'd0);
    check_eq("t3_late_done_busy", 32'(busy_amisha), 32'd0);
    check_eq("t3_late_done_start", 32'(start_amisha), 32'd0);

    // 4: second ch0 edge while ch0 still pending is dropped
    do_reset();
    level_amisha = 4'b0010;
    tick();
    level_amisha = 4'b0000;
    tick();
    check_eq("t4_g1", 32'(grant_amisha), 32'h2);
    tick();
    level_amisha = 4'b0001;
    tick();
    level_amisha = 4'b0000;
    tick();
    level_amisha = 4'b0001;
    tick();
    check_eq("t4_drop", 32'(drop_amisha), 32'h1);
    level_amisha = 4'b0000;
    tick();
    check_eq("t4_drop_pulse", 32'(drop_amisha), 32'h0);
    done_amisha = 1'b1;
    tick();
    done_amisha = 1'b0;
    tick();
    check_eq("t4_g0", 32'(grant_amisha), 32'h1);
    serve();
    tick();
    check_eq("t4_single_busy", 32'(busy_amisha), 32'd0);
    check_eq("t4_single_start", 32'(start_amisha), 32'd0);

    // 5: reset during WAIT clears outputs and pending; held level re-edges
    do_reset();
    level_amisha = 4'b0100;
    tick();
    tick();
    tick();
    level_amisha = 4'b0101;
    tick();
    level_amisha = 4'b0100;
    reset_amisha = 1'b1;
    tick();
    reset_amisha = 1'b0;
    check_eq("t5_start", 32'(start_amisha), 32'd0);
    check_eq("t5_busy", 32'(busy_amisha), 32'd0);
    check_eq("t5_grant", 32'(grant_amisha), 32'd0);
    check_eq("t5_id", 32'(grant_id_amisha), 32'd0);
    check_eq("t5_tmo", 32'(timeout_amisha), 32'd0);
    check_eq("t5_drop", 32'(drop_amisha), 32'd0);
    tick();
    tick();
    check_eq("t5_regrant", 32'(grant_amisha), 32'h4);
    check_eq("t5_restart", 32'(start_amisha), 32'd1);
    serve();
    level_amisha = 4'b0000;
    tick();
    check_eq("t5_no_ch0", 32'(busy_amisha), 32'd0);

    // 6: done in START is ignored
    do_reset();
    level_amisha = 4'b1000;
    tick();
    level_amisha = 4'b0000;
    tick();
    check_eq("t6_g3", 32'(grant_amisha), 32'h8);
    done_amisha = 1'b1;
    tick();
    done_amisha = 1'b0;
    check_eq("t6_busy_after_start_done", 32'(busy_amisha), 32'd1);
    tick();
    check_eq("t6_busy_hold", 32'(busy_amisha), 32'd1);
    done_amisha = 1'b1;
    tick();
    done_amisha = 1'b0;
    check_eq("t6_busy_end", 32'(busy_amisha), 32'd0);
    check_eq("t6_tmo", 32'(timeout_amisha), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
